control_unit_fsm: RTL and testbench

//  Multicycle control FSM that sequences the 64-bit load/store/ALU datapath.
//  - Reads opcode/funct fields from the instruction register output (IR loads every CLK).
//  - Drives sub, WE_RF, WE_MEM, RF_din_sel, ULA_din2_sel, load_pc and reset_pc.
//  - Executes one instruction at a time; traps and halts on unsupported encodings.

---
 rtl/control_unit_fsm_pkg.sv | 52 +++++
 rtl/control_main_decoder.sv | 49 ++++
 rtl/control_unit_fsm.sv | 188 ++++++++++++++++++
 tb/tb_control_unit_fsm.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_unit_fsm_pkg.sv
// Shared encodings and payload types for the multicycle control unit.
package control_unit_fsm_pkg;

    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned FUNCT3_W = 3;
    localparam int unsigned FUNCT7_W = 7;
    localparam int unsigned STATE_W  = 3;

    localparam logic [OPCODE_W-1:0] OP_R  = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_I  = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_LD = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_SD = 7'b0100011;

    localparam logic [FUNCT3_W-1:0] F3_ADD = 3'b000;
    localparam logic [FUNCT3_W-1:0] F3_DW  = 3'b011;

    localparam logic [FUNCT7_W-1:0] F7_ADD = 7'b0000000;
    localparam logic [FUNCT7_W-1:0] F7_SUB = 7'b0100000;

    typedef enum logic [STATE_W-1:0] {
        S_INIT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        CLS_R   = 3'd0,
        CLS_I   = 3'd1,
        CLS_LD  = 3'd2,
        CLS_SD  = 3'd3,
        CLS_ILL = 3'd4
    } instr_class_e;

    // Datapath mux selects, held for the whole instruction
    typedef struct packed {
        logic sub;
        logic din2_sel;
        logic din_sel;
    } ctrl_sel_t;

    // Single-cycle strobes
    typedef struct packed {
        logic we_rf;
        logic we_mem;
        logic load_pc;
    } ctrl_pulse_t;

endpackage

// File: rtl/control_main_decoder.sv
// Combinational instruction classifier: opcode/funct fields to class and mux selects.
module control_main_decoder
    import control_unit_fsm_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNCT3_W-1:0] funct3,
    input  logic [FUNCT7_W-1:0] funct7,
    output instr_class_e        cls_c,
    output ctrl_sel_t           sel_c
);

    always_comb begin
        cls_c = CLS_ILL;
        sel_c = '0;
        case (opcode)
            OP_R: begin
                if (funct3 == F3_ADD && (funct7 == F7_ADD || funct7 == F7_SUB)) begin
                    cls_c         = CLS_R;
                    sel_c.sub     = (funct7 == F7_SUB);
                    sel_c.din_sel = 1'b1;
                end
            end
            OP_I: begin
                // funct7 carries immediate bits here, so it is not examined
                if (funct3 == F3_ADD) begin
                    cls_c          = CLS_I;
                    sel_c.din2_sel = 1'b1;
                    sel_c.din_sel  = 1'b1;
                end
            end
            OP_LD: begin
                if (funct3 == F3_DW) begin
                    cls_c          = CLS_LD;
                    sel_c.din2_sel = 1'b1;
                end
            end
            OP_SD: begin
                if (funct3 == F3_DW) begin
                    cls_c          = CLS_SD;
                    sel_c.din2_sel = 1'b1;
                end
            end
            default: begin
                cls_c = CLS_ILL;
            end
        endcase
    end

endmodule

// File: rtl/control_unit_fsm.sv
// Multicycle control FSM sequencing the 64-bit load/store/ALU datapath.
// Define CTRL_PERF_CNT_EN to add the cycle_cnt/retired_cnt performance counters.
module control_unit_fsm
    import control_unit_fsm_pkg::*;
#(
    parameter int unsigned RESET_HOLD = 2
`ifdef CTRL_PERF_CNT_EN
  , parameter int unsigned CNT_W      = 32
`endif
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                run,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNCT3_W-1:0] funct3,
    input  logic [FUNCT7_W-1:0] funct7,
    output logic                sub,
    output logic                ULA_din2_sel,
    output logic                RF_din_sel,
    output logic                WE_RF,
    output logic                WE_MEM,
    output logic                load_pc,
    output logic                reset_pc,
    output logic                illegal,
    output logic                busy,
    output logic [STATE_W-1:0]  state
`ifdef CTRL_PERF_CNT_EN
  , output logic [CNT_W-1:0]    cycle_cnt,
    output logic [CNT_W-1:0]    retired_cnt
`endif
);

    // A hold of zero would underflow the counter compare; clamp to one
    localparam int unsigned HOLD_N = (RESET_HOLD < 1) ? 1 : RESET_HOLD;
    localparam int unsigned HOLD_W = (HOLD_N > 1) ? $clog2(HOLD_N) : 1;

    state_e       state_q, state_d;
    instr_class_e cls_q, cls_d;
    ctrl_sel_t    sel_q, sel_d;
    ctrl_pulse_t  pulse_q, pulse_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic         reset_pc_q, reset_pc_d;
    logic         illegal_q, illegal_d;
    logic         busy_q, busy_d;

    instr_class_e dec_cls_c;
    ctrl_sel_t    dec_sel_c;

    control_main_decoder u_decoder (
        .opcode (opcode),
        .funct3 (funct3),
        .funct7 (funct7),
        .cls_c  (dec_cls_c),
        .sel_c  (dec_sel_c)
    );

    // Next state plus next registered outputs; pulses are raised on entry to their state
    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        sel_d     = sel_q;
        pulse_d   = '0;
        hold_d    = hold_q;
        illegal_d = illegal_q;

        case (state_q)
            S_INIT: begin
                if (hold_q == HOLD_W'(HOLD_N - 1)) begin
                    state_d = S_FETCH;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            S_FETCH: begin
                if (run) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                cls_d = dec_cls_c;
                if (dec_cls_c == CLS_ILL) begin
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
                end else begin
                    state_d = S_EXEC;
                    sel_d   = dec_sel_c;
                end
            end
            S_EXEC: begin
                case (cls_q)
                    CLS_LD: begin
                        state_d = S_MEM;
                    end
                    CLS_SD: begin
                        state_d         = S_MEM;
                        pulse_d.we_mem  = 1'b1;
                        pulse_d.load_pc = 1'b1;
                    end
                    default: begin
                        state_d         = S_WB;
                        pulse_d.we_rf   = 1'b1;
                        pulse_d.load_pc = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                if (cls_q == CLS_LD) begin
                    state_d         = S_WB;
                    pulse_d.we_rf   = 1'b1;
                    pulse_d.load_pc = 1'b1;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_WB: begin
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                // Unreachable encoding: trap rather than guess
                state_d   = S_HALT;
                illegal_d = 1'b1;
            end
        endcase

        reset_pc_d = (state_d == S_INIT);
        busy_d     = (state_d inside {S_DECODE, S_EXEC, S_MEM, S_WB});
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_INIT;
            cls_q      <= CLS_ILL;
            sel_q      <= '0;
            pulse_q    <= '0;
            hold_q     <= '0;
            reset_pc_q <= 1'b1;
            illegal_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cls_q      <= cls_d;
            sel_q      <= sel_d;
            pulse_q    <= pulse_d;
            hold_q     <= hold_d;
            reset_pc_q <= reset_pc_d;
            illegal_q  <= illegal_d;
            busy_q     <= busy_d;
        end
    end

    assign sub          = sel_q.sub;
    assign ULA_din2_sel = sel_q.din2_sel;
    assign RF_din_sel   = sel_q.din_sel;
    assign WE_RF        = pulse_q.we_rf;
    assign WE_MEM       = pulse_q.we_mem;
    assign load_pc      = pulse_q.load_pc;
    assign reset_pc     = reset_pc_q;
    assign illegal      = illegal_q;
    assign busy         = busy_q;
    assign state        = STATE_W'(state_q);

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] retired_q;

    // Counters see the registered state/strobe, so each counts the cycle just ended
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cycle_q   <= '0;
            retired_q <= '0;
        end else begin
            if (state_q != S_INIT && state_q != S_HALT) begin
                cycle_q <= cycle_q + CNT_W'(1);
            end
            if (pulse_q.load_pc) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    assign cycle_cnt   = cycle_q;
    assign retired_cnt = retired_q;
`endif

endmodule

// File: tb/tb_control_unit_fsm.sv
// Self-checking bench for control_unit_fsm: directed cases plus randomized traffic
// compared every cycle against a per-instruction schedule model.
`timescale 1ns/1ps
module tb_control_unit_fsm;

    localparam int unsigned RESET_HOLD = 2;
    localparam logic [2:0] ST_INIT = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2, ST_EXEC = 3'd3,
                           ST_MEM = 3'd4, ST_WB = 3'd5, ST_HALT = 3'd7;
    localparam int K_ADD = 0, K_SUB = 1, K_ADDI = 2, K_LD = 3, K_SD = 4, K_ILL = 5;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       run;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       sub, ULA_din2_sel, RF_din_sel, WE_RF, WE_MEM, load_pc, reset_pc, illegal, busy;
    logic [2:0] state;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt, retired_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    control_unit_fsm #(.RESET_HOLD(RESET_HOLD)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .run          (run),
        .opcode       (opcode),
        .funct3       (funct3),
        .funct7       (funct7),
        .sub          (sub),
        .ULA_din2_sel (ULA_din2_sel),
        .RF_din_sel   (RF_din_sel),
        .WE_RF        (WE_RF),
        .WE_MEM       (WE_MEM),
        .load_pc      (load_pc),
        .reset_pc     (reset_pc),
        .illegal      (illegal),
        .busy         (busy),
        .state        (state)
`ifdef CTRL_PERF_CNT_EN
      , .cycle_cnt    (cycle_cnt),
        .retired_cnt  (retired_cnt)
`endif
    );

    task automatic check(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [2:0] st;
        logic       we_rf;
        logic       we_mem;
        logic       lpc;
        logic       rpc;
        logic       bsy;
        logic       ill;
    } exp_t;

    function automatic exp_t mk(input logic [2:0] st, input logic rf, input logic mem, input logic lpc);
        exp_t e;
        e.st     = st;
        e.we_rf  = rf;
        e.we_mem = mem;
        e.lpc    = lpc;
        e.rpc    = (st == ST_INIT);
        e.bsy    = !(st == ST_INIT || st == ST_FETCH || st == ST_HALT);
        e.ill    = (st == ST_HALT);
        return e;
    endfunction

    function automatic int classify(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h00) return K_ADD;
        if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h20) return K_SUB;
        if (op == 7'h13 && f3 == 3'd0) return K_ADDI;
        if (op == 7'h03 && f3 == 3'd3) return K_LD;
        if (op == 7'h23 && f3 == 3'd3) return K_SD;
        return K_ILL;
    endfunction

    exp_t   cur;
    exp_t   seq_q[$];
    int     init_left;
    logic   m_sub, m_din2, m_din;
    bit     m_chk_din;
    longint m_cyc, m_ret;

    // Whole remaining schedule of an instruction is queued once it has been decoded
    task automatic start_instr(input int k);
        seq_q.delete();
        case (k)
            K_ADD, K_SUB, K_ADDI: begin
                seq_q.push_back(mk(ST_EXEC, 0, 0, 0));
                seq_q.push_back(mk(ST_WB, 1, 0, 1));
            end
            K_LD: begin
                seq_q.push_back(mk(ST_EXEC, 0, 0, 0));
                seq_q.push_back(mk(ST_MEM, 0, 0, 0));
                seq_q.push_back(mk(ST_WB, 1, 0, 1));
            end
            K_SD: begin
                seq_q.push_back(mk(ST_EXEC, 0, 0, 0));
                seq_q.push_back(mk(ST_MEM, 0, 1, 1));
            end
            default: ;
        endcase
        m_sub     = (k == K_SUB);
        m_din2    = (k == K_ADDI || k == K_LD || k == K_SD);
        m_din     = (k == K_ADD || k == K_SUB || k == K_ADDI);
        m_chk_din = (k != K_SD);
        if (seq_q.size() != 0) cur = seq_q.pop_front();
        else cur = mk(ST_HALT, 0, 0, 0);
    endtask

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cur       = mk(ST_INIT, 0, 0, 0);
            seq_q.delete();
            init_left = RESET_HOLD;
            m_cyc     = 0;
            m_ret     = 0;
        end else begin
            if (cur.st != ST_INIT && cur.st != ST_HALT) m_cyc++;
            if (cur.lpc) m_ret++;
            if (seq_q.size() != 0) begin
                cur = seq_q.pop_front();
            end else begin
                case (cur.st)
                    ST_INIT: begin
                        init_left--;
                        if (init_left <= 0) cur = mk(ST_FETCH, 0, 0, 0);
                    end
                    ST_FETCH:  if (run) cur = mk(ST_DECODE, 0, 0, 0);
                    ST_DECODE: start_instr(classify(opcode, funct3, funct7));
                    ST_HALT:   ;
                    default:   cur = mk(ST_FETCH, 0, 0, 0);
                endcase
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge CLK) begin
        check("state", longint'(state), longint'(cur.st));
        check("WE_RF", longint'(WE_RF), longint'(cur.we_rf));
        check("WE_MEM", longint'(WE_MEM), longint'(cur.we_mem));
        check("load_pc", longint'(load_pc), longint'(cur.lpc));
        check("reset_pc", longint'(reset_pc), longint'(cur.rpc));
        check("busy", longint'(busy), longint'(cur.bsy));
        check("illegal", longint'(illegal), longint'(cur.ill));
        if (cur.st == ST_EXEC || cur.st == ST_MEM || cur.st == ST_WB) begin
            check("sub", longint'(sub), longint'(m_sub));
            check("din2_sel", longint'(ULA_din2_sel), longint'(m_din2));
            if (m_chk_din) check("din_sel", longint'(RF_din_sel), longint'(m_din));
        end
`ifdef CTRL_PERF_CNT_EN
        check("cycle_cnt", longint'(cycle_cnt), m_cyc);
        check("retired_cnt", longint'(retired_cnt), m_ret);
`endif
    end

    // ---------------- stimulus ----------------
    task automatic set_fields(input logic [31:0] w);
        opcode = w[6:0];
        funct3 = w[14:12];
        funct7 = w[31:25];
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic wait_fetch();
        int n = 0;
        while (state != ST_FETCH && n < 20) begin
            tick();
            n++;
        end
        if (state != ST_FETCH) begin
            total++;
            bad++;
            $display("FAIL wait_fetch: got state %0d want %0d", state, ST_FETCH);
        end
    endtask

    // Starts one instruction from FETCH, drops run after the first edge, and pins timing literals
    task automatic exec_instr(input string nm, input logic [31:0] ins, input int lat, input int st4,
                              input int n_rf, input int n_mem, input int e_sub, input int e_din2);
        int pc_at = 0, rf_n = 0, mem_n = 0, s4 = -1, s_sub = -1, s_d2 = -1;
        wait_fetch();
        run = 1'b1;
        set_fields(ins);
        for (int n = 1; n <= 8; n++) begin
            @(negedge CLK);
            if (load_pc && pc_at == 0) pc_at = n;
            rf_n  += int'(WE_RF);
            mem_n += int'(WE_MEM);
            if (n == 4) s4 = int'(state);
            if (n == lat) begin
                s_sub = int'(sub);
                s_d2  = int'(ULA_din2_sel);
            end
            tick();
            run = 1'b0;
        end
        check({nm, "_latency"}, pc_at, lat);
        check({nm, "_state_c4"}, s4, st4);
        check({nm, "_we_rf_pulses"}, rf_n, n_rf);
        check({nm, "_we_mem_pulses"}, mem_n, n_mem);
        check({nm, "_sub"}, s_sub, e_sub);
        check({nm, "_din2_sel"}, s_d2, e_din2);
    endtask

    function automatic logic [31:0] pick_instr();
        logic [31:0] w;
        logic [31:0] hi;
        w  = $urandom() & 32'h01FF_8F80;
        hi = $urandom() & 32'hFE00_0000;
        case ($urandom_range(0, 9))
            0, 1:    w |= 32'h0000_0033;
            2:       w |= 32'h4000_0033;
            3, 4:    w |= 32'h0000_0013 | hi;
            5, 9:    w |= 32'h0000_3003 | hi;
            6:       w |= 32'h0000_3023 | hi;
            7:       w  = $urandom();
            default: begin
                case ($urandom_range(0, 3))
                    0:       w |= 32'h0200_0033;
                    1:       w |= 32'h0000_1013;
                    2:       w |= 32'h0000_2003;
                    default: w |= 32'h0000_007F;
                endcase
            end
        endcase
        return w;
    endfunction

    initial begin
        int pulses;
        RST_N = 1'b0;
        run   = 1'b0;
        set_fields(32'h0000_0013);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_state", longint'(state), 0);
        check("rst_reset_pc", longint'(reset_pc), 1);
        check("rst_strobes", longint'(WE_RF | WE_MEM | load_pc), 0);
        tick();
        RST_N = 1'b1;
        @(negedge CLK);
        check("hold_a_state", longint'(state), 0);
        @(negedge CLK);
        check("hold_b_state", longint'(state), 0);
        check("hold_b_reset_pc", longint'(reset_pc), 1);
        @(negedge CLK);
        check("hold_end_state", longint'(state), 1);
        check("hold_end_reset_pc", longint'(reset_pc), 0);
        tick();

        exec_instr("sub",  32'h4000_0033, 4, 5, 1, 0, 1, 0);
        exec_instr("add",  32'h0000_0033, 4, 5, 1, 0, 0, 0);
        exec_instr("addi", 32'hFFF0_0013, 4, 5, 1, 0, 0, 1);
        exec_instr("ld",   32'h0000_3003, 5, 4, 1, 0, 0, 1);
        exec_instr("sd",   32'hFE00_3023, 4, 4, 0, 1, 0, 1);

        // Asynchronous reset landing in the write-back cycle of an addi
        wait_fetch();
        run = 1'b1;
        set_fields(32'h0010_0013);
        repeat (3) begin
            tick();
            run = 1'b0;
        end
        check("wb_we_rf_before", longint'(WE_RF), 1);
        RST_N = 1'b0;
        #1;
        check("wb_abort_we_rf", longint'(WE_RF), 0);
        check("wb_abort_load_pc", longint'(load_pc), 0);
        check("wb_abort_state", longint'(state), 0);
        tick();
        RST_N = 1'b1;

        // Illegal encoding traps to HALT; run toggling is ignored
        wait_fetch();
        run = 1'b1;
        set_fields(32'h0000_007F);
        tick();
        tick();
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            run = ~run;
            set_fields($urandom());
            tick();
            pulses += int'(WE_RF) + int'(WE_MEM) + int'(load_pc);
        end
        check("halt_state", longint'(state), 7);
        check("halt_illegal", longint'(illegal), 1);
        check("halt_busy", longint'(busy), 0);
        check("halt_pulses", pulses, 0);
        run   = 1'b0;
        RST_N = 1'b0;
        #1;
        check("recover_illegal", longint'(illegal), 0);
        check("recover_state", longint'(state), 0);
        tick();
        RST_N = 1'b1;

`ifdef CTRL_PERF_CNT_EN
        // Three back-to-back addi from the first FETCH after reset
        begin
            int seen = 0;
            wait_fetch();
            run = 1'b1;
            set_fields(32'h0000_0013);
            for (int i = 0; i < 20 && seen < 3; i++) begin
                tick();
                if (load_pc) seen++;
            end
            tick();
            run = 1'b0;
            check("perf_state", longint'(state), 1);
            check("perf_retired", longint'(retired_cnt), 3);
            check("perf_cycles", longint'(cycle_cnt), 12);
        end
`endif

        // Randomized traffic with occasional asynchronous resets
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (!RST_N) RST_N = 1'b1;
            else if (cur.st == ST_HALT ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 299) == 0))
                RST_N = 1'b0;
            run = ($urandom_range(0, 3) != 0);
            if (cur.st == ST_DECODE) set_fields(pick_instr());
            else set_fields($urandom());
        end
        RST_N = 1'b1;
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
